// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and the
// legal WIDTH range.
package serial_adder_pkg;

  // Legal operand width range.
  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;

  // Control FSM state encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // True when w is an operand width the adder supports.
  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// 1-bit full-adder cell, the per-bit datapath of the serial adder.
// Ports:
//   Ain, Bin, Cin : addend bits and carry-in
//   Sum, Cout     : sum bit and carry-out
module serial_adder_full_adder (
  input  logic Ain,
  input  logic Bin,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic w_half;

  assign w_half = Ain ^ Bin;
  assign Sum    = w_half ^ Cin;
  assign Cout   = (Ain & Bin) | (Cin & w_half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, one result bit per clock,
// LSB first, carry held in a flip-flop between bits.
// Ports:
//   Clk, Rst_n : clock, synchronous active-low reset
//   Start      : request, accepted on a rising edge while Busy=0
//   A, B, Cin  : operands and carry-in, sampled on the accepting edge
//   Busy       : high while bits are being added
//   Done       : one-cycle completion pulse
//   Sum, Cout  : result and final carry, held until the next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CNT_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;

  // Reject unsupported widths at elaboration.
  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_adder: WIDTH out of range");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_res_nxt;

  // Per-bit datapath: LSBs of the operand shifters plus the held carry.
  serial_adder_full_adder u_fa (
    .Ain  (r_a_sh[0]),
    .Bin  (r_b_sh[0]),
    .Cin  (r_carry),
    .Sum  (w_fa_sum),
    .Cout (w_fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_res_nxt = WIDTH'({w_fa_sum, r_res} >> 1);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_ADD;
          w_accept    = 1'b1;
        end
      end
      S_ADD: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt = S_DONE;
          w_last      = 1'b1;
        end
      end
      S_DONE: begin
        if (Start) begin
          w_state_nxt = S_ADD;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_ADD);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a_sh  <= A;
        r_b_sh  <= B;
        r_carry <= Cin;
        r_cnt   <= '0;
      end else if (r_state == S_ADD) begin
        r_a_sh  <= r_a_sh >> 1;
        r_b_sh  <= r_b_sh >> 1;
        r_carry <= w_fa_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
        r_res   <= w_res_nxt;
        // Publish the result only on the final bit so Sum/Cout hold during ADD.
        if (w_last) begin
          r_sum  <= w_res_nxt;
          r_cout <= w_fa_cout;
        end
      end
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked every cycle
// against an arithmetic timeline model, plus directed literal checks.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       st8, ci8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       st1, ci1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Rst_n(rst_n), .Start(st8), .A(a8), .B(b8), .Cin(ci8),
    .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .Start(st1), .A(a1), .B(b1), .Cin(ci1),
    .Busy(busy1), .Done(done1), .Sum(sum1), .Cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request yields A+B+Cin exactly WIDTH edges later.
  int          m_left [2];
  bit          m_done [2];
  longint      m_sum  [2];
  bit          m_cout [2];
  longint      m_pend [2];
  bit          m_valid;

  initial begin
    m_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_done[k] = 0; m_sum[k] = 0; m_cout[k] = 0; m_pend[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int     w;
      bit     st;
      longint op;
      w  = (k == 0) ? 8 : 1;
      st = (k == 0) ? st8 : st1;
      op = (k == 0) ? longint'(a8) + longint'(b8) + longint'(ci8)
                    : longint'(a1) + longint'(b1) + longint'(ci1);
      if (!rst_n) begin
        m_left[k] = 0; m_done[k] = 0; m_sum[k] = 0; m_cout[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_done[k] = 1;
          m_sum[k]  = m_pend[k] & ((longint'(1) << w) - 1);
          m_cout[k] = ((m_pend[k] >> w) & 1) != 0;
        end
      end else begin
        m_done[k] = 0;
        if (st) begin
          m_pend[k] = op;
          m_left[k] = w;
        end
      end
    end
    if (!rst_n) m_valid = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy8", 64'(busy8), 64'(m_left[0] > 0));
      chk("done8", 64'(done8), 64'(m_done[0]));
      chk("sum8",  64'(sum8),  64'(m_sum[0]));
      chk("cout8", 64'(cout8), 64'(m_cout[0]));
      chk("busy1", 64'(busy1), 64'(m_left[1] > 0));
      chk("done1", 64'(done1), 64'(m_done[1]));
      chk("sum1",  64'(sum1),  64'(m_sum[1]));
      chk("cout1", 64'(cout1), 64'(m_cout[1]));
    end
  end

  // One WIDTH=8 operation; checks latency and the literal result.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] es, input logic ec, input string nm);
    int k;
    @(negedge clk);
    st8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
    @(negedge clk);
    st8 = 1'b0; a8 = ~a; b8 = ~b; ci8 = ~ci;
    k = 0;
    while (!done8 && k < 40) begin
      chk({nm, "_busy"}, 64'(busy8), 64'(1));
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"},  64'(k), 64'(8));
    chk({nm, "_sum"},  64'(sum8), 64'(es));
    chk({nm, "_cout"}, 64'(cout8), 64'(ec));
  endtask

  // One WIDTH=1 operation; checks latency and {Cout,Sum}.
  task automatic op1(input logic a, input logic b, input logic ci, input logic [1:0] exp);
    int k;
    @(negedge clk);
    st1 = 1'b1; a1 = a; b1 = b; ci1 = ci;
    @(negedge clk);
    st1 = 1'b0;
    k = 0;
    while (!done1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("w1_lat_%0d%0d%0d", a, b, ci), 64'(k), 64'(1));
    chk($sformatf("w1_res_%0d%0d%0d", a, b, ci), 64'({cout1, sum1}), 64'(exp));
  endtask

  // Count Done pulses of the 8-bit instance over n cycles.
  task automatic count_done8(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
  endtask

  initial begin
    int k, nd, t0;
    logic [1:0] tt [8];
    checks = 0; failures = 0;
    rst_n = 1'b0;
    st8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    st1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_done", 64'(done8), 64'(0));
    chk("rst_sum",  64'(sum8),  64'(0));
    chk("rst_cout", 64'(cout8), 64'(0));
    rst_n = 1'b1;

    // Basic additions and carry boundaries.
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "t1");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2b");

    // Start held high: back-to-back operations 9 cycles apart.
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0;
    k = 0;
    while (!done8 && k < 40) begin @(negedge clk); k++; end
    chk("t3_sum1", 64'(sum8), 64'(8'h03));
    a8 = 8'h10; b8 = 8'h20;
    t0 = k;
    @(negedge clk); k++;
    while (!done8 && k < 80) begin @(negedge clk); k++; end
    chk("t3_gap",  64'(k - t0), 64'(9));
    chk("t3_sum2", 64'(sum8), 64'(8'h30));
    st8 = 1'b0;
    repeat (2) @(negedge clk);

    // Start during ADD is ignored.
    st8 = 1'b1; a8 = 8'h21; b8 = 8'h43; ci8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    st8 = 1'b1; a8 = 8'h77; b8 = 8'h11; ci8 = 1'b0;
    @(negedge clk);
    st8 = 1'b0;
    nd = 0; k = 0;
    while (nd == 0 && k < 40) begin
      @(negedge clk); k++;
      if (done8) begin
        nd++;
        chk("t4_sum",  64'(sum8), 64'(8'h65));
        chk("t4_cout", 64'(cout8), 64'(0));
      end
    end
    count_done8(20, k);
    chk("t4_ndone", 64'(nd + k), 64'(1));

    // Reset mid-ADD discards the operation.
    @(negedge clk);
    st8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A; ci8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_busy", 64'(busy8), 64'(0));
    chk("t5_done", 64'(done8), 64'(0));
    chk("t5_sum",  64'(sum8),  64'(0));
    chk("t5_cout", 64'(cout8), 64'(0));
    count_done8(15, nd);
    chk("t5_nodone", 64'(nd), 64'(0));
    op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "t5_new");

    // WIDTH=1 truth table in A,B,Cin order.
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
    tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0], tt[i]);
    end

    // Randomized traffic on both instances, with rare resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      st8   = ($urandom_range(0, 3) == 0);
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      ci8   = 1'($urandom);
      st1   = ($urandom_range(0, 1) == 0);
      a1    = 1'($urandom);
      b1    = 1'($urandom);
      ci1   = 1'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; st8 = 1'b0; st1 = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
